// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for pipelined_ripple_adder.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_ripple_adder_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] A;
  logic [data_width-1:0] B;
  logic                  C_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] Sum;
  logic                  C_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  V_out;

  modport master (
    output A, B, C_in, in_valid, out_ready,
    input  in_ready, Sum, C_out, out_valid, V_out
  );

  modport slave (
    input  A, B, C_in, in_valid, out_ready,
    output in_ready, Sum, C_out, out_valid, V_out
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// STAGES-slice pipelined ripple-carry adder with valid/ready on both sides.
// Define ADDER_OVF_DETECT_EN to add a registered signed-overflow flag on V_out.
module pipelined_ripple_adder #(
  parameter int data_width = 8,
  parameter int STAGES     = 4
) (
  input logic                      clk,
  input logic                      rst,
  pipelined_ripple_adder_if.slave  adder_io
);
  localparam int CHUNK = data_width / STAGES;

  if (data_width % STAGES != 0) begin : g_cfg_err
    $error("pipelined_ripple_adder: data_width must be a multiple of STAGES");
  end

  logic adv;
  logic out_valid;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv               = adder_io.out_ready | ~out_valid;
  assign adder_io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still ahead of this slice; chunk k sits in the low CHUNK bits.
    localparam int LO  = k * CHUNK;
    localparam int OPW = data_width - LO;

    logic [OPW-1:0]      a_in;
    logic [OPW-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [CHUNK:0]      cc;
    logic [CHUNK-1:0]    s_d;
    logic [LO+CHUNK-1:0] sum_d;
    logic [LO+CHUNK-1:0] sum_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_first
      assign a_in  = adder_io.A;
      assign b_in  = adder_io.B;
      assign c_in  = adder_io.C_in;
      assign v_in  = adder_io.in_valid;
      assign sum_d = s_d;
    end else begin : g_next
      assign a_in  = g_stg[k-1].g_ops.a_q;
      assign b_in  = g_stg[k-1].g_ops.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign sum_d = {s_d, g_stg[k-1].sum_q};
    end

    always_comb begin
      cc    = '0;
      s_d   = '0;
      cc[0] = c_in;
      for (int i = 0; i < CHUNK; i++) begin
        s_d[i]  = a_in[i] ^ b_in[i] ^ cc[i];
        cc[i+1] = (a_in[i] & b_in[i]) | (cc[i] & (a_in[i] ^ b_in[i]));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= cc[CHUNK];
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [OPW-CHUNK-1:0] a_q;
      logic [OPW-CHUNK-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[OPW-1:CHUNK];
          b_q <= b_in[OPW-1:CHUNK];
        end
      end
    end

`ifdef ADDER_OVF_DETECT_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Carry into the MSB versus carry out of it, captured alongside the top chunk.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cc[CHUNK] ^ cc[CHUNK-1];
        end
      end
    end
`endif
  end

  assign out_valid          = g_stg[STAGES-1].v_q;
  assign adder_io.out_valid = out_valid;
  assign adder_io.Sum       = g_stg[STAGES-1].sum_q;
  assign adder_io.C_out     = g_stg[STAGES-1].c_q;

`ifdef ADDER_OVF_DETECT_EN
  assign adder_io.V_out = g_stg[STAGES-1].g_ovf.ovf_q;
`else
  assign adder_io.V_out = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed and random adds scored against an arithmetic model.
// Also checks STAGES=1 and STAGES=8 latency on separate instances.
module tb_pipelined_ripple_adder;
  localparam int DW = 8;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.data_width(DW)) m  ();
  pipelined_ripple_adder_if #(.data_width(DW)) m1 ();
  pipelined_ripple_adder_if #(.data_width(DW)) m8 ();

  pipelined_ripple_adder #(.data_width(DW), .STAGES(ST)) u_dut (.clk(clk), .rst(rst), .adder_io(m));
  pipelined_ripple_adder #(.data_width(DW), .STAGES(1))  u_s1  (.clk(clk), .rst(rst), .adder_io(m1));
  pipelined_ripple_adder #(.data_width(DW), .STAGES(8))  u_s8  (.clk(clk), .rst(rst), .adder_io(m8));

  typedef struct {
    logic [DW:0] val;
    logic        v;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   n_out    = 0;
  bit   chk_lat  = 1'b0;
  bit   done     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: model is plain arithmetic on the accepted operands.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("in_ready", 32'(m.in_ready), 32'(!(m.out_valid && !m.out_ready)));
      if (m.out_valid && m.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(m.out_valid), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          chk("sum", 32'({m.C_out, m.Sum}), 32'(e.val));
`ifdef ADDER_OVF_DETECT_EN
          chk("v_out", 32'(m.V_out), 32'(e.v));
`else
          chk("v_out", 32'(m.V_out), 32'(0));
`endif
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(ST));
        end
      end
      if (m.in_valid && m.in_ready) begin
        exp_t e;
        int   s;
        e.val = {1'b0, m.A} + {1'b0, m.B} + {{DW{1'b0}}, m.C_in};
        s     = int'($signed(m.A)) + int'($signed(m.B)) + int'(m.C_in);
        e.v   = (s > 127) || (s < -128);
        e.cyc = cyc;
        e.lat = chk_lat;
        exp_q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    m.A = a; m.B = b; m.C_in = c; m.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = m.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    m.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int   lat1, lat8, stale;
    logic [DW:0] r1, r8;

    m.A = '0;  m.B = '0;  m.C_in = 1'b0;  m.in_valid = 1'b0;  m.out_ready = 1'b1;
    m1.A = '0; m1.B = '0; m1.C_in = 1'b0; m1.in_valid = 1'b0; m1.out_ready = 1'b1;
    m8.A = '0; m8.B = '0; m8.C_in = 1'b0; m8.in_valid = 1'b0; m8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(m.out_valid), 32'(0));
    chk("rst_sum", 32'({m.C_out, m.Sum}), 32'(0));
    chk("rst_v_out", 32'(m.V_out), 32'(0));
    chk("rst_in_ready", 32'(m.in_ready), 32'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // STAGES=1 and STAGES=8 instances: AA+55+1
    m1.A = 8'hAA; m1.B = 8'h55; m1.C_in = 1'b1; m1.in_valid = 1'b1;
    m8.A = 8'hAA; m8.B = 8'h55; m8.C_in = 1'b1; m8.in_valid = 1'b1;
    @(posedge clk); #1;
    m1.in_valid = 1'b0; m8.in_valid = 1'b0;
    lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
    for (int n = 1; n <= 20; n++) begin
      if (lat1 == 0 && m1.out_valid) begin lat1 = n; r1 = {m1.C_out, m1.Sum}; end
      if (lat8 == 0 && m8.out_valid) begin lat8 = n; r8 = {m8.C_out, m8.Sum}; end
      @(posedge clk); #1;
    end
    chk("s1_latency", 32'(lat1), 32'(1));
    chk("s1_sum", 32'(r1), 32'h100);
    chk("s8_latency", 32'(lat8), 32'(8));
    chk("s8_sum", 32'(r8), 32'h100);

    // Directed adds on the 4-stage instance with latency tracking
    chk_lat = 1'b1;
    send(8'hAA, 8'h55, 1'b0);
    drain();
    send(8'hFF, 8'h00, 1'b1);
    drain();
    send(8'hFC, 8'h07, 1'b1);
    send(8'h7F, 8'h01, 1'b0);
    drain();

    // Random stream under a 1,0,0 out_ready pattern
    chk_lat = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        int p;
        p = 0;
        while (!done) begin
          m.out_ready = (p % 3 == 0);
          p++;
          @(posedge clk); #1;
        end
      end
    join
    m.out_ready = 1'b1;
    drain();

    // Reset with three adds in flight
    chk_lat = 1'b1;
    send(8'h12, 8'h34, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    send(8'hF0, 8'h0F, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(m.out_valid), 32'(0));
    chk("midrst_sum", 32'({m.C_out, m.Sum}), 32'(0));
    chk("midrst_v_out", 32'(m.V_out), 32'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m.out_valid) stale++;
    end
    chk("stale_after_rst", 32'(stale), 32'(0));
    n_acc = 0;
    n_out = 0;
    @(posedge clk); #1;
    send(8'h3C, 8'hC3, 1'b1);
    drain();
    chk("post_rst_count", 32'(n_out), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
